// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the banked SRAM controller.
package mem_ctrl_pkg;

  localparam int unsigned DW         = 8;
  localparam int unsigned AW         = 16;
  localparam int unsigned NBANK      = 4;
  localparam int unsigned BANK_AW    = AW - 2;
  localparam int unsigned BANK_DEPTH = 2 ** BANK_AW;

  typedef logic [1:0]         bank_sel_t;
  typedef logic [BANK_AW-1:0] bank_addr_t;
  typedef logic [DW-1:0]      data_t;

  // Byte address split into bank select and in-bank offset.
  typedef struct packed {
    bank_sel_t  bank;
    bank_addr_t offset;
  } addr_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous RAM bank with a registered read port (1-cycle latency).
module mem_bank
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       we,
  input  bank_addr_t addr,
  input  data_t      din,
  output data_t      dout
);

  data_t mem [BANK_DEPTH];
  data_t dout_d, dout_q;

  // Read register only updates on a read, so it holds across writes and idles.
  always_comb begin
    dout_d = dout_q;
    if (en && !we) begin
      dout_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= din;
    end
    dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_ctrl.sv
// SRAM-style control decoder over four 16 KiB banks with registered read data.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [AW-1:0] ADDR,
  input  logic          CE,
  input  logic          CSB,
  input  logic          WEB,
  input  logic          OEB,
  input  logic [DW-1:0] IDATA,
  output logic [DW-1:0] ODATA
);

  addr_t            addr_f;
  logic             sel;
  logic             wr;
  logic             rd;
  logic [NBANK-1:0] bank_en;
  data_t            bank_dout [NBANK];

  logic      rd_valid_d, rd_valid_q;
  bank_sel_t rd_bank_d, rd_bank_q;

  assign addr_f = addr_t'(ADDR);

  // Access decode; a reset cycle suppresses every access, and a write wins over a read.
  always_comb begin
    sel     = CE & ~CSB & ~RSTN;
    wr      = sel & ~WEB;
    rd      = sel & WEB & ~OEB;
    bank_en = '0;
    for (int unsigned i = 0; i < NBANK; i++) begin
      bank_en[i] = (wr | rd) && (addr_f.bank == bank_sel_t'(i));
    end
  end

  for (genvar g = 0; g < int'(NBANK); g++) begin : g_bank
    mem_bank u_bank (
      .clk  (CLK),
      .en   (bank_en[g]),
      .we   (wr),
      .addr (addr_f.offset),
      .din  (IDATA),
      .dout (bank_dout[g])
    );
  end

  // Remember which bank supplied the last read so the output mux tracks it.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_bank_d  = rd_bank_q;
    if (rd) begin
      rd_valid_d = 1'b1;
      rd_bank_d  = addr_f.bank;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Bank read registers hold between reads; reset forces zero until the next read.
  always_comb begin
    ODATA = rd_valid_q ? bank_dout[rd_bank_q] : '0;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: driver queues expected ODATA, negedge monitor checks it.
module tb_mem_ctrl;

  logic        CLK;
  logic        RSTN;
  logic [15:0] ADDR;
  logic        CE;
  logic        CSB;
  logic        WEB;
  logic        OEB;
  logic [7:0]  IDATA;
  logic [7:0]  ODATA;

  mem_ctrl dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .ADDR  (ADDR),
    .CE    (CE),
    .CSB   (CSB),
    .WEB   (WEB),
    .OEB   (OEB),
    .IDATA (IDATA),
    .ODATA (ODATA)
  );

  // kind 1: ODATA must equal exp; kind 2: ODATA must not be any bank-offset-0 value
  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge CLK);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_run++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: check missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
        end else if (e.kind == 1 && ODATA !== e.exp) begin
          n_fail++;
          $display("FAIL %s: ODATA=%h expected %h", e.name, ODATA, e.exp);
        end else if (e.kind == 2 && (ODATA === 8'hA5 || ODATA === 8'h3C ||
                                     ODATA === 8'h81 || ODATA === 8'h7E)) begin
          n_fail++;
          $display("FAIL %s: ODATA=%h leaked from another bank", e.name, ODATA);
        end
      end
    end
  end

  task automatic op(input logic rst, input logic ce, input logic csb, input logic web,
                    input logic oeb, input logic [15:0] a, input logic [7:0] d,
                    input int kind, input logic [7:0] x, input string nm);
    exp_t t;
    @(posedge CLK);
    #1;
    RSTN = rst; CE = ce; CSB = csb; WEB = web; OEB = oeb; ADDR = a; IDATA = d;
    if (kind != 0) begin
      t.cyc  = cyc + 1;
      t.kind = kind;
      t.exp  = x;
      t.name = nm;
      sb_q.push_back(t);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int kind,
                    input logic [7:0] x, input string nm);
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a, d, kind, x, nm);
  endtask

  task automatic rd(input logic [15:0] a, input int kind, input logic [7:0] x,
                    input string nm);
    op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00, kind, x, nm);
  endtask

  task automatic idle(input logic [7:0] x, input string nm);
    op(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1, x, nm);
  endtask

  initial begin
    RSTN = 1'b1; CE = 1'b0; CSB = 1'b1; WEB = 1'b1; OEB = 1'b1;
    ADDR = 16'h0000; IDATA = 8'h00;

    // reset, including a write attempt that must be dropped
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1, 8'h00, "rst_idle0");
    op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1, 8'h00, "rst_idle1");
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hEE, 1, 8'h00, "rst_wr0");
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hEE, 1, 8'h00, "rst_wr1");

    // per-bank writes then readback
    wr(16'h0000, 8'hA5, 1, 8'h00, "wr_b0");
    wr(16'h4000, 8'h3C, 1, 8'h00, "wr_b1");
    wr(16'h8000, 8'h81, 1, 8'h00, "wr_b2");
    wr(16'hC000, 8'h7E, 1, 8'h00, "wr_b3");
    rd(16'h0000, 1, 8'hA5, "rd_b0");
    rd(16'h4000, 1, 8'h3C, "rd_b1");
    rd(16'h8000, 1, 8'h81, "rd_b2");
    rd(16'hC000, 1, 8'h7E, "rd_b3");

    // bank isolation
    rd(16'h0001, 2, 8'h00, "iso_b0");
    rd(16'h4001, 2, 8'h00, "iso_b1");
    rd(16'h8001, 2, 8'h00, "iso_b2");
    rd(16'hC001, 2, 8'h00, "iso_b3");
    wr(16'h3FFF, 8'h55, 0, 8'h00, "wr_edge0");
    wr(16'h4000, 8'hAA, 0, 8'h00, "wr_edge1");
    rd(16'h3FFF, 1, 8'h55, "rd_edge0");
    rd(16'h4000, 1, 8'hAA, "rd_edge1");

    // qualifier gating
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hFF, 1, 8'hAA, "ce0_wr");
    op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'hFF, 1, 8'hAA, "csb1_wr");
    rd(16'h0000, 1, 8'hA5, "rd_after_gated_wr");
    op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 8'h00, 1, 8'hA5, "ce0_rd");
    op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 8'h00, 1, 8'hA5, "csb1_rd");

    // write/read conflict and hold
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 8'h12, 1, 8'hA5, "conflict");
    idle(8'hA5, "hold0");
    idle(8'hA5, "hold1");
    rd(16'h8000, 1, 8'h12, "rd_conflict");

    // back-to-back and toggling reads
    wr(16'hC010, 8'h99, 1, 8'h12, "b2b_wr");
    rd(16'hC010, 1, 8'h99, "b2b_rd");
    rd(16'h0000, 1, 8'hA5, "tog0");
    rd(16'hC010, 1, 8'h99, "tog1");
    rd(16'h0000, 1, 8'hA5, "tog2");
    rd(16'hC010, 1, 8'h99, "tog3");

    // reset mid-operation drops the access
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hEE, 1, 8'h00, "rst_mid_wr");
    op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC010, 8'h00, 1, 8'h00, "rst_mid_rd");
    rd(16'h0000, 1, 8'hA5, "rd_after_rst");
    idle(8'hA5, "hold_after_rst");

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port SRAM controller for a 64 KiB, 8-bit-wide memory split into four 16 KiB banks.
- Decodes a classic SRAM-style control interface into per-bank accesses:
  - CE: active-high enable.
  - CSB, WEB, OEB: active-low chip select, write enable and output enable.
- Returns registered read data.
- Sits between a bus/host master and the on-chip memory banks.

Parameters:
- DW, 8, data width in bits.
- AW, 16, byte address width.
- NBANK, 4, number of banks; bank select = ADDR[AW-1:AW-2].
- BANK_AW, AW-2 (14), per-bank address width; bank depth = 2**BANK_AW.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RSTN  input  1  synchronous, active-high reset. Asserted = 1; the name is historical.
- ADDR  input  AW  byte address. [15:14] = bank, [13:0] = offset within bank.
- CE  input  1  access enable, active-high.
- CSB  input  1  chip select, active-low.
- WEB  input  1  write enable, active-low.
- OEB  input  1  output/read enable, active-low.
- IDATA  input  DW  write data.
- ODATA  output  DW  registered read data.

Behaviour:
- Access qualifier: sel = CE & ~CSB. No access when sel = 0; memory is untouched and ODATA holds.
- Write: on a rising edge with sel & ~WEB, write IDATA to bank ADDR[15:14] at offset ADDR[13:0]. Exactly one bank is written per cycle.
- Read: on a rising edge with sel & WEB & ~OEB, read the addressed byte into the ODATA register. ODATA is valid immediately after that edge (1-cycle latency).
- Write/read conflict: WEB=0 and OEB=0 together counts as a write only. ODATA holds its previous value.
- ODATA holds its last read value until the next read or reset. There is no tri-state; OEB only qualifies reads.
- Bank decode:
  - 0x0000–0x3FFF → bank0
  - 0x4000–0x7FFF → bank1
  - 0x8000–0xBFFF → bank2
  - 0xC000–0xFFFF → bank3
- Each bank is enabled only when selected; unselected banks see no write and no read enable.
- Reset: while RSTN=1 at a rising edge:
  - ODATA is set to 0.
  - Any concurrent read or write is suppressed.
  - Memory contents are not cleared. Unwritten locations read X in simulation.
- Reset mid-operation: an access presented in a reset cycle is dropped entirely. It is not retried.
- Back-to-back accesses on consecutive cycles are supported, with no wait states.
- A read of an address written in the previous cycle returns the new data.
- Address wrap: none needed; the full AW range maps onto the banks.
- X-safety: when sel=0, the values of ADDR, IDATA, WEB and OEB have no effect.

Decomposition:
- Package mem_ctrl_pkg:
  - DW, AW, NBANK, BANK_AW constants.
  - Typedefs bank_sel_t (2 bits), bank_addr_t (BANK_AW bits), data_t (DW bits).
- One sub-module, mem_bank: single-port synchronous RAM with en, we, addr, din and registered dout, 1-cycle read latency.
- Top instantiates NBANK copies via generate. It then does decode, enable gating and output mux.
- Registered-output rule: the mux uses a one-cycle-delayed bank select. The ODATA register holds its value when no read occurred.

Test Plan:
- Reset: RSTN=1 for 4 cycles with CE=0 → ODATA=0. No memory writes occur, even if WEB=0 is presented during reset.
- Per-bank write/readback:
  - Write 0xA5 @0x0000, 0x3C @0x4000, 0x81 @0x8000, 0x7E @0xC000; each pulse is CE=1, CSB=0, WEB=0 for one cycle.
  - Then read each address (OEB=0, WEB=1) → ODATA equals the written byte one cycle after each read edge.
- Bank isolation: after the writes above, read 0x0001, 0x4001, 0x8001, 0xC001. ODATA is not 0xA5/0x3C/0x81/0x7E from a wrong bank. Then write 0x55 @0x3FFF and 0xAA @0x4000 → reads return 0x55 and 0xAA respectively.
- Qualifier gating:
  - CE=0 or CSB=1 with WEB=0, IDATA=0xFF @0x0000 → a later read of 0x0000 still returns 0xA5.
  - CE=0 with OEB=0 → ODATA unchanged.
- Conflict and hold:
  - WEB=0, OEB=0, IDATA=0x12 @0x8000 → ODATA unchanged that cycle; a later read returns 0x12.
  - With idle cycles after a read, ODATA holds its value.
- Back-to-back: consecutive-cycle write 0x99 @0xC010, then read 0xC010 → ODATA=0x99 on the following edge. Alternating reads to 0x0000 and 0xC010 → ODATA toggles 0xA5/0x99 every cycle.
